pipelined_segmented_adder: RTL
==============================

// Module: pipelined_segmented_adder
// PURPOSE
//   Parametrised, pipelined successor to the fixed 64-bit segmented ripple adder. Splits
//   WIDTH-bit operands into SEG_WIDTH segments and adds one segment per pipeline stage,
//   registering the carry between stages. Adds add/subtract mode, signed-overflow flag and
//   valid/ready flow control. Sustains one operation per clock; sits in front of the ALU result mux.
// PARAMETERS
//   WIDTH      64  operand/sum width; must be a multiple of SEG_WIDTH
//   SEG_WIDTH  16  bits added per stage; NUM_SEG = WIDTH/SEG_WIDTH (>=1) = pipeline depth
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands/mode/c_in valid this cycle
//   in_ready   out  1      block can accept; transfer when in_valid && in_ready
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   c_in       in   1      carry in (ignored when sub=1)
//   sub        in   1      0: a+b+c_in; 1: a-b (a + ~b + 1)
//   out_valid  out  1      sum/c_out/ovf valid
//   out_ready  in   1      consumer accepts; transfer when out_valid && out_ready
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   c_out      out  1      carry out of MSB (for sub: 1 = no borrow)
//   ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (rst_n=0, async): all stage valid bits, data, carry registers cleared; out_valid=0,
//     sum=0, c_out=0, ovf=0. in_ready=1 once rst_n deasserts (pipe empty). Reset mid-operation
//     discards every in-flight operation; nothing emerges afterwards.
//   - Stage k (0..NUM_SEG-1) holds: valid_k, carry_k, partial sum bits [(k+1)*SEG_WIDTH-1:0],
//     remaining operand bits of a and b-effective, sub flag. Stage 0 adds segment 0 of a and
//     b_eff = sub ? ~b : b with cin = sub ? 1 : c_in. Stage k adds segment k with carry_{k-1}.
//   - Latency: exactly NUM_SEG cycles from input handshake to out_valid (no stall).
//     Outputs come directly from the last stage register.
//   - Throughput 1 op/clock. Global stall: stall = out_valid && !out_ready; in_ready = !stall.
//     On stall every stage holds its contents; no bubble is dropped or duplicated.
//   - When not stalled, pipe advances; a stage with no incoming valid loads valid=0 (bubble).
//   - Simultaneous out handshake and in handshake in same cycle is legal and lossless.
//   - ovf computed in final stage from the MSB-segment carries; valid for both modes.
//   - NUM_SEG=1: degenerates to a single registered adder, latency 1.
//   - Inputs sampled only on handshake; a/b/sub/c_in may change freely otherwise.
// STRUCTURE
//   - Package adder_pkg: localparam defaults (WIDTH, SEG_WIDTH), function num_seg(),
//     typedef for stage record {valid, carry, sum bits, op bits, sub}.
//   - Sub-module seg_adder #(SEG_WIDTH): combinational SEG_WIDTH-bit add with c_in,
//     outputs sum, c_out and carry into MSB (for ovf); instantiated NUM_SEG times via generate.
//   - Top: skew/deskew registers, valid chain, stall logic.
// TESTING
//   1. Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0, in_ready=1 after release.
//   2. Default params, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, c_in=0, sub=0 -> after 4 clks sum=0,
//      c_out=1, ovf=0 (carry ripples through all stages).
//   3. sub=1, a=5, b=7 -> sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0; a=64'h8000_0000_0000_0000,
//      b=1 -> sum=64'h7FFF_FFFF_FFFF_FFFF, ovf=1.
//   4. Back-to-back 100 random ops, out_ready=1 -> results in order, one per clk, match model.
//   5. Random out_ready toggling (50%) with continuous in_valid -> no loss/duplication,
//      outputs stable while stalled, in_ready=0 exactly when out_valid && !out_ready.
//   6. Assert rst_n low with 3 ops in flight -> none emerge; WIDTH=32,SEG_WIDTH=8 and
//      WIDTH=SEG_WIDTH=16 builds pass tests 2-4 with latency 4 and 1.

Source files
------------

// File: rtl/pipelined_segmented_adder_pkg.sv
// Shared defaults and helpers for the pipelined segmented adder.
package pipelined_segmented_adder_pkg;

  localparam int DEFAULT_WIDTH     = 64;
  localparam int DEFAULT_SEG_WIDTH = 16;

  // Pipeline depth: one stage per segment.
  function automatic int num_seg(input int width, input int seg_width);
    return width / seg_width;
  endfunction

endpackage

// File: rtl/pipelined_segmented_adder_if.sv
// Operand/result handshake bundle between the ALU front end and the segmented adder.
interface pipelined_segmented_adder_if
  import pipelined_segmented_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

endinterface

// File: rtl/pipelined_segmented_adder_seg.sv
// One combinational segment add; also exposes the carry into the segment MSB for overflow.
module pipelined_segmented_adder_seg #(
  parameter int SEG_WIDTH = 16
) (
  input  logic [SEG_WIDTH-1:0] a_i,
  input  logic [SEG_WIDTH-1:0] b_i,
  input  logic                 c_i,
  output logic [SEG_WIDTH-1:0] sum_o,
  output logic                 c_o,
  output logic                 c_msb_o
);

  logic [SEG_WIDTH:0] full_s;

  assign full_s  = {1'b0, a_i} + {1'b0, b_i} + {{SEG_WIDTH{1'b0}}, c_i};
  assign sum_o   = full_s[SEG_WIDTH-1:0];
  assign c_o     = full_s[SEG_WIDTH];
  // Sum MSB = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
  assign c_msb_o = full_s[SEG_WIDTH-1] ^ a_i[SEG_WIDTH-1] ^ b_i[SEG_WIDTH-1];

endmodule

// File: rtl/pipelined_segmented_adder.sv
// Pipelined segmented adder: one SEG_WIDTH slice per stage, carry registered between stages,
// global stall when the result is not taken.
module pipelined_segmented_adder
  import pipelined_segmented_adder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipelined_segmented_adder_if.slave   bus
);

  localparam int NSEG = num_seg(WIDTH, SEG_WIDTH);
  localparam int SW   = SEG_WIDTH;

  if ((SEG_WIDTH < 1) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_bad_params
    $error("WIDTH must be a non-zero multiple of SEG_WIDTH");
  end

  logic             stall_s;
  logic             advance_s;
  logic             valid_q    [NSEG];
  logic             carry_q    [NSEG];
  logic [WIDTH-1:0] sum_q      [NSEG];
  logic [WIDTH-1:0] a_q        [NSEG];
  logic [WIDTH-1:0] b_q        [NSEG];
  logic             seg_cmsb_s [NSEG];
  logic             ovf_q;

  assign stall_s   = valid_q[NSEG-1] && !bus.out_ready;
  assign advance_s = !stall_s;

  assign bus.in_ready  = advance_s;
  assign bus.out_valid = valid_q[NSEG-1];
  assign bus.sum       = sum_q[NSEG-1];
  assign bus.c_out     = carry_q[NSEG-1];
  assign bus.ovf       = ovf_q;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic             src_valid_s;
    logic             src_carry_s;
    logic [WIDTH-1:0] src_sum_s;
    logic [WIDTH-1:0] src_a_s;
    logic [WIDTH-1:0] src_b_s;
    logic [SW-1:0]    seg_sum_s;
    logic             seg_cout_s;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;

    if (k == 0) begin : g_first
      // Subtraction is folded in here as a + ~b + 1; later stages never see the mode.
      assign src_valid_s = bus.in_valid;
      assign src_carry_s = bus.sub ? 1'b1 : bus.c_in;
      assign src_sum_s   = '0;
      assign src_a_s     = bus.a;
      assign src_b_s     = bus.sub ? ~bus.b : bus.b;
    end else begin : g_next
      assign src_valid_s = valid_q[k-1];
      assign src_carry_s = carry_q[k-1];
      assign src_sum_s   = sum_q[k-1];
      assign src_a_s     = a_q[k-1];
      assign src_b_s     = b_q[k-1];
    end

    pipelined_segmented_adder_seg #(
      .SEG_WIDTH (SW)
    ) u_seg (
      .a_i     (src_a_s[SW-1:0]),
      .b_i     (src_b_s[SW-1:0]),
      .c_i     (src_carry_s),
      .sum_o   (seg_sum_s),
      .c_o     (seg_cout_s),
      .c_msb_o (seg_cmsb_s[k])
    );

    // Remaining operand bits shift down so the next segment is always at bit 0.
    assign sum_d = src_sum_s | (WIDTH'(seg_sum_s) << (k * SW));
    assign a_d   = src_a_s >> SW;
    assign b_d   = src_b_s >> SW;

    // Stage register: holds on stall, loads a bubble when nothing valid arrives.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end else if (advance_s) begin
        valid_q[k] <= src_valid_s;
        if (src_valid_s) begin
          carry_q[k] <= seg_cout_s;
          sum_q[k]   <= sum_d;
          a_q[k]     <= a_d;
          b_q[k]     <= b_d;
        end
      end
    end

    if (k == NSEG - 1) begin : g_last
      logic ovf_d;

      assign ovf_d = seg_cmsb_s[k] ^ seg_cout_s;

      // Signed overflow is resolved alongside the top segment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance_s && src_valid_s) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

endmodule
